// File: rtl/miriscv_pkg.sv
// Core-wide constants and the multiply/divide unit's op and state encodings.
package miriscv_pkg;

    localparam int XLEN  = 32;
    localparam bit RV32M = 1'b1;

    localparam int MDU_CNT_W = $clog2(XLEN);

    // Encoded exactly as the RV32M funct3 field
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state_e;

endpackage

// File: rtl/miriscv_mdu.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide
// step per cycle over operand magnitudes, followed by a single sign-fix cycle.
module miriscv_mdu #(
    parameter int XLEN = miriscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] port_a_i,
    input  logic [XLEN-1:0] port_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    import miriscv_pkg::*;

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negation through an XLEN+1-bit intermediate; |INT_MIN| stays representable unsigned
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        logic [XLEN:0] t;
        t = ~{1'b0, v} + (XLEN+1)'(1);
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? negate(v) : v;
    endfunction

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic [XLEN-1:0]   opa_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   res_q;
    logic [XLEN-1:0]   result_q;

    mdu_op_e         op_in;
    logic            is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        op_in     = mdu_op_e'(op_i);
        is_div_in = op_i[2];
        a_signed  = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                    (op_in == MDU_DIV)  || (op_in == MDU_REM);
        b_signed  = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
        a_neg     = a_signed & port_a_i[XLEN-1];
        b_neg     = b_signed & port_b_i[XLEN-1];
        // REM takes the dividend's sign; every other signed op the product/quotient sign
        neg_in    = (op_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);
        mag_a     = cond_neg(port_a_i, a_neg);
        mag_b     = cond_neg(port_b_i, b_neg);
        div_zero  = is_div_in && (port_b_i == '0);
        div_ovf   = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (port_a_i == INT_MIN) && (port_b_i == '1);
        special   = div_zero | div_ovf;
        if (op_i[1])
            special_res = div_zero ? port_a_i : '0;
        else
            special_res = div_zero ? '1 : port_a_i;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        // Multiply: high half accumulates the multiplicand, whole register shifts right
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        // Divide: high half is the partial remainder, low half shifts dividend out / quotient in
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opa_q};
        div_ge    = ~div_diff[XLEN];
        div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        prod      = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
        case (op_q)
            MDU_MUL:                          fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_res = cond_neg(acc_q[XLEN-1:0], neg_q);
            default:                          fix_res = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= MDU_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: if (req_i) state_d = special ? MDU_DONE : MDU_CALC;
                MDU_CALC: if (cnt_q == '0) state_d = MDU_FIX;
                MDU_FIX:  state_d = MDU_DONE;
                MDU_DONE: state_d = MDU_IDLE;
                default:  state_d = MDU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
        end else if (!kill_i) begin
            case (state_q)
                MDU_IDLE: begin
                    if (req_i) begin
                        op_q  <= op_in;
                        neg_q <= neg_in;
                        cnt_q <= CNT_W'(XLEN-1);
                        opa_q <= is_div_in ? mag_b : mag_a;
                        acc_q <= {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                        if (special)
                            res_q <= special_res;
                    end
                end
                MDU_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                MDU_FIX:  res_q <= fix_res;
                MDU_DONE: result_q <= res_q;
                default: ;
            endcase
        end
    end

    // A killed DONE neither pulses valid nor disturbs the visible result
    assign busy_o   = (state_q != MDU_IDLE);
    assign valid_o  = (state_q == MDU_DONE) && !kill_i;
    assign result_o = valid_o ? res_q : result_q;
    assign stall_o  = (req_i | busy_o) & ~valid_o;

endmodule

// File: tb/tb_miriscv_mdu.sv
// Self-checking bench for miriscv_mdu: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_miriscv_mdu;

    logic        clk, rst, req, kill;
    logic [2:0]  op;
    logic [31:0] pa, pb;
    logic        busy, stall, valid;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    miriscv_mdu #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .op_i     (op),
        .port_a_i (pa),
        .port_b_i (pb),
        .kill_i   (kill),
        .busy_o   (busy),
        .stall_o  (stall),
        .valid_o  (valid),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics written directly with wide integer arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    // Issue one op from IDLE, optionally scrambling inputs while it is in flight
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [31:0] res, output int lat, output bit stall_ok);
        @(negedge clk);
        req = 1'b1; op = o; pa = a; pb = b;
        stall_ok = 1'b1; lat = 0; res = 32'hDEADBEEF;
        #1;
        if (!stall) stall_ok = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                lat = n;
                res = result;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            if (scramble) begin
                op = 3'($urandom);
                pa = $urandom;
                pb = $urandom;
            end
        end
        req = 1'b0;
    endtask

    task automatic wait_valid(output int n_out);
        n_out = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                n_out = n;
                break;
            end
        end
    endtask

    logic [31:0] res, r2, exp_r;
    int          lat, n, seen;
    bit          sok;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
        vecs[4]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
        vecs[5]  = '{3'd5, 32'd100,        32'd7,        32'd14,       34};
        vecs[6]  = '{3'd7, 32'd100,        32'd7,        32'd2,        34};
        vecs[7]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{3'd6, 32'd5,          32'd0,        32'd5,        1};
        vecs[9]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[11] = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34};
        vecs[12] = '{3'd4, 32'd7,          32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{3'd7, 32'h12345678,   32'd0,        32'h12345678, 1};

        rst = 1'b1; req = 1'b0; kill = 1'b0; op = 3'd0; pa = '0; pb = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, busy, valid, stall, 1'b0}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, sok);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_stall", i), {31'd0, sok}, 32'd1);
        end

        // Kill in cycle 10 of a divide: back to idle, no pulse, result unchanged
        @(negedge clk);
        req = 1'b1; op = 3'd4; pa = 32'd1000; pb = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        chk("kill_no_valid", 32'(seen), 32'd0);
        chk("kill_result_held", result, vecs[13].exp);
        run_op(3'd0, 32'd3, 32'd4, 1'b0, res, lat, sok);
        chk("after_kill_mul", res, 32'd12);
        chk("after_kill_lat", 32'(lat), 32'd34);

        // Kill during DONE suppresses valid and keeps the old result
        @(negedge clk);
        req = 1'b1; op = 3'd5; pa = 32'd100; pb = 32'd7;
        wait_valid(n);
        chk("done_kill_reach", 32'(n), 32'd34);
        kill = 1'b1; req = 1'b0;
        #1;
        chk("done_kill_valid", {31'd0, valid}, 32'd0);
        chk("done_kill_result", result, 32'd12);
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        chk("done_kill_idle", {31'd0, busy}, 32'd0);
        chk("done_kill_result2", result, 32'd12);

        // req & kill together in IDLE: nothing accepted
        @(negedge clk);
        req = 1'b1; kill = 1'b1; op = 3'd0; pa = 32'd9; pb = 32'd9;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; kill = 1'b0;
        chk("req_kill_idle", {30'd0, busy, valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("req_kill_idle2", {30'd0, busy, valid}, 32'd0);

        // Back-to-back: request held through DONE, next op accepted right after
        @(negedge clk);
        req = 1'b1; op = 3'd0; pa = 32'd6; pb = 32'd7;
        wait_valid(n);
        chk("b2b_first", result, 32'd42);
        op = 3'd7; pa = 32'd50; pb = 32'd8;
        wait_valid(n);
        req = 1'b0;
        chk("b2b_interval", 32'(n), 32'd35);
        chk("b2b_second", result, 32'd2);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        req = 1'b1; op = 3'd3; pa = 32'hFFFF0000; pb = 32'h00FF00FF;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        #1;
        chk("midop_reset_ctl", {29'd0, busy, valid, stall}, 32'd0);
        chk("midop_reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        chk("midop_reset_quiet", 32'(seen), 32'd0);

        // Randomized ops, biased towards boundary operands
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)), res, lat, sok);
            exp_r = ref_mdu(ro, ra, rb);
            chk($sformatf("rand%0d_op%0d_result", t, ro), res, exp_r);
            chk($sformatf("rand%0d_op%0d_latency", t, ro), 32'(lat), 32'(ref_lat(ro, ra, rb)));
            r2 = result;
            @(negedge clk);
            chk($sformatf("rand%0d_hold", t), result, r2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
